// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit and its datapath:
// state codes, opcode/funct values, ALU op and mux select encodings.
package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  // States that stall on the shared memory and feed the timeout counter.
  function automatic logic is_mem_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multi_cycle_control_mem_wait_timer.sv
// Counts consecutive stalled memory cycles; flags the cycle that hits the limit.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  output logic expired
);
  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count;

  // count_en drops on ready or on leaving a wait state, so both clear the run.
  always_ff @(posedge clk) begin
    if (reset || !count_en || expired) count <= '0;
    else                               count <= count + 1'b1;
  end

  assign expired = count_en && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: one state per datapath step, shared memory
// stalls with a timeout trap, sticky trap on illegal opcodes.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       branch_eq_o,
  output logic       branch_ne_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e state, next_state;
  ctrl_t  ctrl, ctrl_out;
  logic   wait_en, wait_expired;

  assign wait_en = is_mem_wait_state(state) && !mem_ready_i;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .count_en (wait_en),
    .expired  (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (mem_ready_i) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          next_state    = S_DECODE;
        end else if (wait_expired) begin
          next_state = S_TRAP;
        end
      end
      S_DECODE: begin
        // ALUOut picks up the branch target while the opcode is decoded.
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
        case (opcode_i)
          OP_RTYPE:                         next_state = (funct_i == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:                     next_state = S_MEM_ADDR;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: next_state = S_I_EXEC;
          OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
          OP_J:                             next_state = S_JUMP;
          OP_JAL:                           next_state = S_JAL;
          default:                          next_state = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        if (mem_ready_i)       next_state = S_MEM_WB;
        else if (wait_expired) next_state = S_TRAP;
      end
      S_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready_i) begin
          ctrl.instr_done = 1'b1;
          next_state      = S_FETCH;
        end else if (wait_expired) begin
          next_state = S_TRAP;
        end
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
        next_state     = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        case (opcode_i)
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_LUI:  ctrl.alu_op = ALU_LUI;
          default: ctrl.alu_op = ALU_ADD;
        endcase
        next_state = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end
      S_BRANCH: begin
        // PC load is qualified with ALU zero outside this block.
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.branch_eq  = (opcode_i == OP_BEQ);
        ctrl.branch_ne  = (opcode_i == OP_BNE);
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end
      S_JR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_REG;
        ctrl.instr_done = 1'b1;
        next_state      = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_TRAP;
    endcase
  end

  // Reset masks everything combinationally so nothing strobes before the edge.
  assign ctrl_out = reset ? '0 : ctrl;

  assign pc_write_o   = ctrl_out.pc_write;
  assign branch_eq_o  = ctrl_out.branch_eq;
  assign branch_ne_o  = ctrl_out.branch_ne;
  assign i_or_d_o     = ctrl_out.i_or_d;
  assign mem_read_o   = ctrl_out.mem_read;
  assign mem_write_o  = ctrl_out.mem_write;
  assign ir_write_o   = ctrl_out.ir_write;
  assign reg_write_o  = ctrl_out.reg_write;
  assign reg_dst_o    = ctrl_out.reg_dst;
  assign mem_to_reg_o = ctrl_out.mem_to_reg;
  assign alu_src_a_o  = ctrl_out.alu_src_a;
  assign alu_src_b_o  = ctrl_out.alu_src_b;
  assign alu_op_o     = ctrl_out.alu_op;
  assign pc_source_o  = ctrl_out.pc_source;
  assign instr_done_o = ctrl_out.instr_done;
  assign illegal_o    = !reset && (state == S_TRAP);
  assign state_o      = reset ? S_FETCH : state;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max consecutive wait cycles on mem_ready_i before trapping.
REQ-002 SHALL have ports, clock and reset first:
  clk  input  1  rising-edge clock
  reset  input  1  synchronous, active-high reset
  opcode_i  input  6  IR[31:26]
  funct_i  input  6  IR[5:0]
  mem_ready_i  input  1  shared instruction/data memory access complete this cycle
  pc_write_o  output  1  unconditional PC load
  branch_eq_o / branch_ne_o  output  1 each  conditional PC load, qualified externally with ALU zero
  i_or_d_o  output  1  memory address: 0 PC, 1 ALUOut
  mem_read_o / mem_write_o  output  1 each  memory strobes
  ir_write_o  output  1  IR load
  reg_write_o  output  1  register file write
  reg_dst_o  output  2  00 rt, 01 rd, 10 r31
  mem_to_reg_o  output  2  00 ALUOut, 01 MDR, 10 PC
  alu_src_a_o  output  1  0 PC, 1 A
  alu_src_b_o  output  2  00 B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
  alu_op_o  output  3  000 add, 001 sub, 010 funct-decoded, 011 or, 100 and, 101 lui
  pc_source_o  output  2  00 ALU result, 01 ALUOut, 10 {PC[31:28],target,00}, 11 A
  instr_done_o  output  1  one-cycle pulse on last cycle of each instruction
  illegal_o  output  1  sticky trap flag
  state_o  output  4  current state code

Function
REQ-003 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, TRAP.
REQ-004 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; ir_write and pc_write SHALL assert only in the cycle mem_ready_i=1, then go to DECODE; else remain in FETCH.
REQ-005 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target precompute); next state by opcode: 0x00 with funct 0x08 -> JR, 0x00 other -> R_EXEC, 0x23/0x2B -> MEM_ADDR, 0x08/0x0D/0x0C/0x0F -> I_EXEC, 0x04/0x05 -> BRANCH, 0x02 -> JUMP, 0x03 -> JAL, any other -> TRAP.
REQ-006 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; to MEM_RD if lw else MEM_WR.
REQ-007 MEM_RD/MEM_WR: i_or_d=1, strobe held until mem_ready_i=1; MEM_RD -> MEM_WB; MEM_WR -> FETCH with instr_done.
REQ-008 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1 -> FETCH.
REQ-009 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB (reg_write, reg_dst=01, mem_to_reg=00, instr_done) -> FETCH.
REQ-010 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op 000 addi, 011 ori, 100 andi, 101 lui -> I_WB (reg_write, reg_dst=00, mem_to_reg=00, instr_done) -> FETCH.
REQ-011 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, branch_eq (0x04) or branch_ne (0x05), instr_done -> FETCH.
REQ-012 JUMP: pc_write, pc_source=10. JAL: same plus reg_write, reg_dst=10, mem_to_reg=10. JR: pc_write, pc_source=11. Each asserts instr_done -> FETCH.
REQ-013 Latency with mem_ready_i=1 every cycle: lw 5, sw/R/I 4, branch/jump/jal/jr 3 cycles.
REQ-014 Wait counter SHALL count consecutive mem_ready_i=0 cycles in FETCH/MEM_RD/MEM_WR, clear on ready or state change; reaching MEM_TIMEOUT SHALL enter TRAP.
REQ-015 TRAP: all strobes 0, illegal_o=1, held until reset.
REQ-016 Outputs not listed for a state SHALL be 0; strobes SHALL never assert outside their listed states.

Reset
REQ-017 reset=1 at a clock edge SHALL force FETCH, clear wait counter and illegal_o, from any state including mid-wait or TRAP.
REQ-018 While reset=1, all strobes, instr_done_o and illegal_o SHALL be 0; state_o shows FETCH.

Structure
REQ-019 State codes, opcode/funct constants, alu_op and mux select encodings SHALL live in a shared package used by datapath and control.
REQ-020 Next-state/output decode in one always block; wait counter as sub-module mem_wait_timer.

Verification
REQ-021 add (opcode 0x00, funct 0x20), ready always 1 -> states FETCH,DECODE,R_EXEC,R_WB; instr_done on cycle 4; reg_dst=01.
REQ-022 lw (0x23), ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, total 8 cycles, mem_to_reg=01 in MEM_WB.
REQ-023 bne (0x05) -> 3 cycles, branch_ne=1, alu_op=001, pc_source=01 in BRANCH.
REQ-024 jal (0x03) -> reg_dst=10, mem_to_reg=10, pc_source=10, pc_write=1 in cycle 3.
REQ-025 opcode 0x3F -> TRAP after DECODE, illegal_o=1 sticky; ready low 15 cycles in FETCH -> TRAP; reset -> FETCH, illegal_o=0.
REQ-026 reset asserted in MEM_WR while waiting -> next cycle FETCH, mem_write_o=0.
